// File: rtl/ws2812b_receiver.sv
// rtl/ws2812b_receiver.sv - WS2812B NRZ line decoder producing per-LED GRB pixels and frame strobes
module ws2812b_receiver #(
  parameter int NB_LEDS    = 12,
  parameter int T_MIN_HIGH = 5,
  parameter int T_THRESH   = 30,
  parameter int T_MAX_HIGH = 60,
  parameter int T_RESET    = 2500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       data_ws2812b,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [7:0] address,
  output logic       pixel_valid,
  output logic       frame_done,
  output logic [7:0] pixel_count,
  output logic       error,
  output logic       busy
);

  localparam int CW = 12;
  localparam logic [CW-1:0] T_MIN_HIGH_C = CW'(T_MIN_HIGH);
  localparam logic [CW-1:0] T_THRESH_C   = CW'(T_THRESH);
  localparam logic [CW-1:0] T_MAX_HIGH_C = CW'(T_MAX_HIGH);
  localparam logic [CW-1:0] T_RESET_C    = CW'(T_RESET);
  localparam logic [7:0]    NB_LEDS_C    = 8'(NB_LEDS);

  typedef enum logic [1:0] {SYNC_WAIT, IDLE, HIGH, LOW} state_t;

  state_t        state, state_nx;
  logic          sync1, din_s;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic [23:0]   sr, sr_nx;
  logic [4:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    pixel_idx, pixel_idx_nx;
  logic [7:0]    pend_addr;
  logic          busy_nx, px_fire, px_pend, done_nx, err_nx;

  // One counter serves as high width, low width or resync length depending on state.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    sr_nx        = sr;
    bit_cnt_nx   = bit_cnt;
    pixel_idx_nx = pixel_idx;
    busy_nx      = busy;
    px_fire      = 1'b0;
    done_nx      = 1'b0;
    err_nx       = 1'b0;
    case (state)
      SYNC_WAIT: begin
        if (din_s) begin
          cnt_nx = '0;
        end else if (cnt_inc >= T_RESET_C) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      IDLE: begin
        if (din_s) begin
          state_nx = HIGH;
          cnt_nx   = CW'(1);
          busy_nx  = 1'b1;
        end
      end
      HIGH: begin
        if ((din_s && cnt_inc > T_MAX_HIGH_C) || (!din_s && cnt < T_MIN_HIGH_C)) begin
          state_nx     = SYNC_WAIT;
          cnt_nx       = din_s ? '0 : CW'(1);
          err_nx       = 1'b1;
          busy_nx      = 1'b0;
          pixel_idx_nx = '0;
          bit_cnt_nx   = '0;
        end else if (din_s) begin
          cnt_nx = cnt_inc;
        end else begin
          sr_nx    = {sr[22:0], (cnt >= T_THRESH_C)};
          state_nx = LOW;
          cnt_nx   = CW'(1);
          if (bit_cnt == 5'd23) begin
            bit_cnt_nx = '0;
            px_fire    = (pixel_idx < NB_LEDS_C);
            if (pixel_idx != 8'hFF) pixel_idx_nx = pixel_idx + 8'd1;
          end else begin
            bit_cnt_nx = bit_cnt + 5'd1;
          end
        end
      end
      LOW: begin
        if (din_s) begin
          state_nx = HIGH;
          cnt_nx   = CW'(1);
        end else if (cnt_inc >= T_RESET_C) begin
          // A dangling partial pixel is flagged alongside the frame end.
          state_nx     = IDLE;
          cnt_nx       = '0;
          done_nx      = 1'b1;
          err_nx       = (bit_cnt != 5'd0);
          busy_nx      = 1'b0;
          pixel_idx_nx = '0;
          bit_cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      default: state_nx = SYNC_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= 1'b0;
      din_s     <= 1'b0;
      state     <= SYNC_WAIT;
      cnt       <= '0;
      sr        <= '0;
      bit_cnt   <= '0;
      pixel_idx <= '0;
      busy      <= 1'b0;
      px_pend   <= 1'b0;
      pend_addr <= '0;
    end else begin
      sync1     <= data_ws2812b;
      din_s     <= sync1;
      state     <= state_nx;
      cnt       <= cnt_nx;
      sr        <= sr_nx;
      bit_cnt   <= bit_cnt_nx;
      pixel_idx <= pixel_idx_nx;
      busy      <= busy_nx;
      px_pend   <= px_fire;
      if (px_fire) pend_addr <= pixel_idx;
    end
  end

  // sr is stable for at least one cycle after the 24th bit, so it is read here directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      address     <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      pixel_count <= '0;
      error       <= 1'b0;
    end else begin
      pixel_valid <= px_pend;
      if (px_pend) begin
        green   <= sr[23:16];
        red     <= sr[15:8];
        blue    <= sr[7:0];
        address <= pend_addr;
      end
      frame_done <= done_nx;
      if (done_nx) pixel_count <= pixel_idx;
      error <= err_nx;
    end
  end

endmodule

// File: tb/tb_ws2812b_receiver.sv
// tb/tb_ws2812b_receiver.sv - randomized self-checking bench for ws2812b_receiver
module tb_ws2812b_receiver;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       data_ws2812b = 1'b0;
  logic [7:0] red, green, blue, address, pixel_count;
  logic       pixel_valid, frame_done, error, busy;

  ws2812b_receiver dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_ws2812b (data_ws2812b),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .address      (address),
    .pixel_valid  (pixel_valid),
    .frame_done   (frame_done),
    .pixel_count  (pixel_count),
    .error        (error),
    .busy         (busy)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] px_q[$];
  int          px_cyc_q[$];
  logic [8:0]  fd_q[$];
  int          err_only = 0;
  int          err_cyc = 0;
  always @(negedge clk) begin
    if (pixel_valid) begin
      px_q.push_back({address, green, red, blue});
      px_cyc_q.push_back(cyc);
    end
    if (frame_done) fd_q.push_back({error, pixel_count});
    else if (error) begin
      err_only = err_only + 1;
      err_cyc  = cyc;
    end
  end

  logic [23:0] tx_pix[16];
  int last_fall_cyc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    data_ws2812b = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit rnd);
    int hi, lo;
    if (rnd) begin
      hi = b ? int'($urandom_range(60, 30)) : int'($urandom_range(29, 5));
      lo = int'($urandom_range(30, 6));
    end else begin
      hi = b ? 40 : 20;
      lo = b ? 21 : 41;
    end
    drive(1'b1, hi);
    last_fall_cyc = cyc;
    drive(1'b0, lo);
  endtask

  task automatic send_pixel(input logic [23:0] p, input int nbits, input bit rnd);
    for (int i = 23; i >= 24 - nbits; i--) send_bit(p[i], rnd);
  endtask

  task automatic fill_pix();
    for (int k = 0; k < 16; k++) tx_pix[k] = 24'($urandom);
  endtask

  task automatic check_frame(input string tag, input int npix, input int extra, input int pb, input int fb);
    int nrep;
    nrep = (npix < 12) ? npix : 12;
    check_eq({tag, "_npx"}, 64'(px_q.size() - pb), 64'(nrep));
    for (int i = 0; i < nrep; i++)
      if (pb + i < px_q.size())
        check_eq({tag, "_px"}, 64'(px_q[pb+i]), 64'({8'(i), tx_pix[i]}));
    check_eq({tag, "_nfd"}, 64'(fd_q.size() - fb), 64'd1);
    if (fd_q.size() > fb)
      check_eq({tag, "_fd"}, 64'(fd_q[fb]), 64'({(extra != 0), 8'((npix > 255) ? 255 : npix)}));
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic run_frame(input string tag, input int npix, input int extra, input bit rnd);
    int pb, fb;
    pb = px_q.size();
    fb = fd_q.size();
    for (int k = 0; k < npix; k++) send_pixel(tx_pix[k], 24, rnd);
    if (extra != 0) send_pixel(tx_pix[npix], extra, rnd);
    drive(1'b0, 2600);
    check_frame(tag, npix, extra, pb, fb);
  endtask

  initial begin
    int pb, fb, eb, k, p0_fall;
    int tbl[4];
    tbl = '{5, 29, 30, 60};

    reset_n = 1'b0;
    drive(1'b0, 3);
    check_eq("reset_out", 64'({red, green, blue, address, pixel_valid, frame_done, pixel_count, error, busy}), 64'd0);
    reset_n = 1'b1;
    drive(1'b0, 2600);
    check_eq("sync_no_fd", 64'(fd_q.size()), 64'd0);

    // Directed two-pixel frame with latency check on the first pixel.
    tx_pix[0] = 24'hFF0000;
    tx_pix[1] = 24'h0000AA;
    pb = px_q.size();
    fb = fd_q.size();
    send_pixel(tx_pix[0], 24, 1'b0);
    p0_fall = last_fall_cyc;
    check_eq("busy_mid", 64'(busy), 64'd1);
    send_pixel(tx_pix[1], 24, 1'b0);
    drive(1'b0, 3000);
    check_frame("two_px", 2, 0, pb, fb);
    if (px_cyc_q.size() > pb) check_eq("latency", 64'(px_cyc_q[pb]), 64'(p0_fall + 4));

    // Threshold boundaries: widths 5,29,30,60 decode as 0,0,1,1.
    tx_pix[0] = 24'h333333;
    pb = px_q.size();
    fb = fd_q.size();
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, tbl[i % 4]);
      drive(1'b0, 6);
    end
    drive(1'b0, 2600);
    check_frame("bound", 1, 0, pb, fb);

    fill_pix();
    run_frame("fourteen", 14, 0, 1'b1);
    for (int f = 0; f < 2; f++) begin
      fill_pix();
      run_frame("rand", int'($urandom_range(4, 1)), 0, 1'b1);
    end

    // 3-cycle glitch mid-frame.
    fill_pix();
    pb = px_q.size();
    fb = fd_q.size();
    eb = err_only;
    send_pixel(tx_pix[0], 5, 1'b1);
    drive(1'b1, 3);
    drive(1'b0, 2600);
    check_eq("glitch_err", 64'(err_only - eb), 64'd1);
    check_eq("glitch_px", 64'(px_q.size() - pb), 64'd0);
    check_eq("glitch_fd", 64'(fd_q.size() - fb), 64'd0);
    check_eq("glitch_busy", 64'(busy), 64'd0);
    run_frame("after_glitch", 1, 0, 1'b1);

    // 80-cycle high: error on the 61st high cycle.
    fill_pix();
    pb = px_q.size();
    fb = fd_q.size();
    eb = err_only;
    send_pixel(tx_pix[0], 2, 1'b0);
    k = cyc;
    drive(1'b1, 80);
    drive(1'b0, 2600);
    check_eq("long_err", 64'(err_only - eb), 64'd1);
    check_eq("long_err_cyc", 64'(err_cyc), 64'(k + 63));
    check_eq("long_px", 64'(px_q.size() - pb), 64'd0);
    check_eq("long_fd", 64'(fd_q.size() - fb), 64'd0);
    run_frame("after_long", 2, 0, 1'b1);

    // 30 bits: one pixel then partial pixel flagged with frame_done.
    fill_pix();
    eb = err_only;
    run_frame("partial", 1, 6, 1'b1);
    check_eq("partial_noerr", 64'(err_only - eb), 64'd0);

    // Reset during bit 12 of pixel 0, then resume without line reset.
    fill_pix();
    pb = px_q.size();
    fb = fd_q.size();
    eb = err_only;
    send_pixel(tx_pix[0], 11, 1'b0);
    drive(1'b1, 10);
    check_eq("rst_busy_pre", 64'(busy), 64'd1);
    #3 reset_n = 1'b0;
    #1 check_eq("rst_async", 64'({red, green, blue, address, pixel_valid, frame_done, pixel_count, error, busy}), 64'd0);
    drive(1'b1, 2);
    reset_n = 1'b1;
    drive(1'b1, 10);
    drive(1'b0, 21);
    send_pixel(tx_pix[1], 24, 1'b0);
    drive(1'b0, 2600);
    check_eq("rst_px", 64'(px_q.size() - pb), 64'd0);
    check_eq("rst_fd", 64'(fd_q.size() - fb), 64'd0);
    check_eq("rst_err", 64'(err_only - eb), 64'd0);
    fill_pix();
    run_frame("after_rst", 2, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ws2812b_receiver.md
Name: ws2812b_receiver

Overview:
Decodes a WS2812B single-wire NRZ pulse stream back into per-LED GRB words, sampled on the 50 MHz system clock. It sits on the far end of the ws2812b line: it is used as a loopback checker for the LED ring transmitter and as an input stage for boards that are themselves driven by a WS2812B stream. Bits are classified by high-pulse width, assembled MSB-first into 24-bit pixels, and frames are delimited by the line reset (long low).

Parameters:
NB_LEDS, 12, number of pixels reported per frame; pixels at index >= NB_LEDS are decoded but not reported
T_MIN_HIGH, 5, minimum legal high width in clk cycles; shorter is a glitch error
T_THRESH, 30, high width >= T_THRESH decodes as 1, else 0 (0.6 us at 50 MHz)
T_MAX_HIGH, 60, high width > T_MAX_HIGH is an error
T_RESET, 2500, low width reaching T_RESET ends the frame (50 us at 50 MHz)

Ports:
clk  input  1  system clock, 50 MHz
reset_n  input  1  asynchronous active-low reset
data_ws2812b  input  1  asynchronous WS2812B line
red  output  8  decoded red of last pixel
green  output  8  decoded green of last pixel
blue  output  8  decoded blue of last pixel
address  output  8  index of last pixel in frame, 0..NB_LEDS-1
pixel_valid  output  1  one-cycle strobe: red/green/blue/address valid
frame_done  output  1  one-cycle strobe: line reset detected after >=1 bit
pixel_count  output  8  complete pixels in finished frame, saturates at 255; valid with frame_done
error  output  1  one-cycle strobe: protocol violation
busy  output  1  high from first rising edge of a frame until frame_done/error

Behaviour:
- Reset (async, reset_n=0): all outputs 0; synchronizer flops 0; state SYNC_WAIT; counters, bit/pixel counters cleared. Reset mid-frame discards everything.
- Input: 2-flop synchronizer -> din_s; edges detected on din_s vs its previous value. All widths count din_s cycles.
- States: SYNC_WAIT: count consecutive din_s=0; reaching T_RESET -> IDLE (no frame_done); any 1 restarts count. IDLE: rising edge -> HIGH, busy=1, high counter=1. HIGH: count while din_s=1; count > T_MAX_HIGH -> error, SYNC_WAIT; falling edge with count < T_MIN_HIGH -> error, SYNC_WAIT; else bit = (count >= T_THRESH), shift into 24-bit register MSB first, bit_cnt++ -> LOW with low counter=1. LOW: rising edge -> HIGH; low count reaching T_RESET -> end of frame -> IDLE.
- Pixel: on 24th bit, bit_cnt=0; if pixel_idx < NB_LEDS, next cycle pixel_valid=1 with green=sr[23:16], red=sr[15:8], blue=sr[7:0], address=pixel_idx; pixel_idx saturates at 255. Colour/address outputs hold until next pixel_valid.
- Latency: pixel_valid asserts exactly 4 clk edges after the first edge sampling data_ws2812b=0 at end of 24th bit.
- End of frame: frame_done=1 for one cycle, pixel_count=pixel_idx, busy=0, pixel_idx=0. If bit_cnt != 0 (partial pixel), error also pulses same cycle; partial bits discarded, pixel_count counts only complete pixels.
- Error: one-cycle pulse, busy=0, pixel_idx/bit_cnt cleared, no frame_done (except partial-pixel case above).
- Counters saturate (no wrap) at their terminal values; 12-bit width sufficient for T_RESET.
- pixel_valid and frame_done never assert in the same cycle as an unrelated stale pixel; a pixel completing in the same cycle as nothing else is always reported before its frame_done.

Test Plan:
- Frame of 2 pixels, 1 bits = 40 cycles high/21 low, 0 bits = 20 high/41 low, GRB = 0xFF0000, 0x0000AA, then 3000-cycle low -> pixel_valid x2: (g=FF,r=00,b=00,addr 0), (g=00,r=00,b=AA,addr 1); frame_done with pixel_count=2.
- 14 pixels with NB_LEDS=12 -> 12 pixel_valid strobes, addresses 0..11; frame_done pixel_count=14.
- High pulse of 3 cycles mid-frame -> error pulse, busy=0, no pixel_valid, next frame after 2500-cycle low decodes normally.
- High pulse of 80 cycles -> error at cycle 61 of high, SYNC_WAIT until 2500 low cycles.
- 30 bits then long low -> one pixel_valid, then frame_done pixel_count=1 with error in same cycle.
- reset_n pulled low at bit 12 of pixel 0 -> all outputs 0 immediately; stream resumes without 2500-cycle low -> ignored until line low for T_RESET.
